// File: rtl/sb_stage_scheduler.sv
// Superblock sequencer: walks the superblock grid in raster order, runs the four decode stages per
// superblock through start/done handshakes, then streams the output-write bursts.
module sb_stage_scheduler #(
    parameter int unsigned SB_LOG2   = 6,
    parameter int unsigned BURST_PIX = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_frame_width,
    input  logic [15:0] i_frame_height,
    output logic        o_ent_start,
    output logic        o_itx_start,
    output logic        o_pred_start,
    output logic        o_recon_start,
    input  logic        i_ent_done,
    input  logic        i_itx_done,
    input  logic        i_pred_done,
    input  logic        i_recon_done,
    output logic [15:0] o_sb_row,
    output logic [15:0] o_sb_col,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [31:0] o_wr_offset,
    output logic        o_busy,
    output logic        o_tile_done,
    output logic        o_error
);

    typedef enum logic [3:0] {
        StIdle, StSetup, StHdr, StEnt, StItx, StPred, StRecon, StNext, StWrite, StDone
    } state_e;

    localparam logic [16:0] SB_ROUND = 17'((1 << SB_LOG2) - 1);

    state_e      r_state, w_state_next;
    logic [15:0] r_frame_w, r_frame_h;
    logic [15:0] r_sb_cols, r_sb_rows;
    logic [31:0] r_total_pix;
    logic [15:0] r_sb_row, r_sb_col;
    logic [31:0] r_wr_offset;
    logic        r_wr_valid, r_busy, r_tile_done, r_error;
    logic        r_ent_start, r_itx_start, r_pred_start, r_recon_start;

    logic [15:0] w_sb_cols, w_sb_rows;
    logic [31:0] w_wr_next;
    logic        w_zero_dim, w_last_col, w_last_row, w_beat, w_wr_end;
    logic        w_ent_start_next, w_itx_start_next, w_pred_start_next, w_recon_start_next;
    logic        w_wr_valid_next, w_busy_next, w_tile_done_next, w_error_next;

    // 17-bit round-up so a 65535-pixel edge cannot wrap
    assign w_sb_cols  = 16'(({1'b0, r_frame_w} + SB_ROUND) >> SB_LOG2);
    assign w_sb_rows  = 16'(({1'b0, r_frame_h} + SB_ROUND) >> SB_LOG2);
    assign w_zero_dim = (r_frame_w == 16'd0) || (r_frame_h == 16'd0);
    assign w_last_col = (r_sb_col == r_sb_cols - 16'd1);
    assign w_last_row = (r_sb_row == r_sb_rows - 16'd1);
    assign w_beat     = (r_state == StWrite) && r_wr_valid && i_wr_ready;
    assign w_wr_next  = r_wr_offset + 32'(BURST_PIX);
    assign w_wr_end   = (w_wr_next >= r_total_pix);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A stage's done is ignored while its own start pulse is still high
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StSetup;
            StSetup: w_state_next = w_zero_dim ? StIdle : StHdr;
            StHdr:   w_state_next = StEnt;
            StEnt:   if (i_ent_done && !r_ent_start) w_state_next = StItx;
            StItx:   if (i_itx_done && !r_itx_start) w_state_next = StPred;
            StPred:  if (i_pred_done && !r_pred_start) w_state_next = StRecon;
            StRecon: if (i_recon_done && !r_recon_start) w_state_next = StNext;
            StNext:  w_state_next = (w_last_col && w_last_row) ? StWrite : StHdr;
            StWrite: if (w_beat && w_wr_end) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_ent_start_next   = (w_state_next == StEnt) && (r_state != StEnt);
        w_itx_start_next   = (w_state_next == StItx) && (r_state != StItx);
        w_pred_start_next  = (w_state_next == StPred) && (r_state != StPred);
        w_recon_start_next = (w_state_next == StRecon) && (r_state != StRecon);
        w_wr_valid_next    = (w_state_next == StWrite);
        w_busy_next        = (w_state_next != StIdle);
        w_tile_done_next   = (w_state_next == StDone);
        w_error_next       = (r_state == StSetup) && w_zero_dim;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_w     <= '0;
            r_frame_h     <= '0;
            r_sb_cols     <= '0;
            r_sb_rows     <= '0;
            r_total_pix   <= '0;
            r_sb_row      <= '0;
            r_sb_col      <= '0;
            r_wr_offset   <= '0;
            r_wr_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_tile_done   <= 1'b0;
            r_error       <= 1'b0;
            r_ent_start   <= 1'b0;
            r_itx_start   <= 1'b0;
            r_pred_start  <= 1'b0;
            r_recon_start <= 1'b0;
        end else begin
            r_wr_valid    <= w_wr_valid_next;
            r_busy        <= w_busy_next;
            r_tile_done   <= w_tile_done_next;
            r_error       <= w_error_next;
            r_ent_start   <= w_ent_start_next;
            r_itx_start   <= w_itx_start_next;
            r_pred_start  <= w_pred_start_next;
            r_recon_start <= w_recon_start_next;
            if (r_state == StIdle && i_start) begin
                r_frame_w   <= i_frame_width;
                r_frame_h   <= i_frame_height;
                r_sb_row    <= '0;
                r_sb_col    <= '0;
                r_wr_offset <= '0;
            end
            if (r_state == StSetup) begin
                r_sb_cols   <= w_sb_cols;
                r_sb_rows   <= w_sb_rows;
                r_total_pix <= 32'(r_frame_w) * 32'(r_frame_h);
            end
            if (r_state == StNext) begin
                if (!w_last_col) begin
                    r_sb_col <= r_sb_col + 16'd1;
                end else if (!w_last_row) begin
                    r_sb_col <= '0;
                    r_sb_row <= r_sb_row + 16'd1;
                end
            end
            if (w_beat) begin
                r_wr_offset <= w_wr_next;
            end
        end
    end

    assign o_ent_start   = r_ent_start;
    assign o_itx_start   = r_itx_start;
    assign o_pred_start  = r_pred_start;
    assign o_recon_start = r_recon_start;
    assign o_sb_row      = r_sb_row;
    assign o_sb_col      = r_sb_col;
    assign o_wr_valid    = r_wr_valid;
    assign o_wr_offset   = r_wr_offset;
    assign o_busy        = r_busy;
    assign o_tile_done   = r_tile_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_sb_stage_scheduler.sv
// Directed bench for sb_stage_scheduler: engine models with programmable done latency, a negedge
// monitor tallying pulses/beats, and immediate-assertion checks against hand-computed values.
module tb_sb_stage_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] fw = '0, fh = '0;
    logic        ent_start, itx_start, pred_start, recon_start;
    logic        ent_done, itx_done, pred_done, recon_done;
    logic [15:0] sb_row, sb_col;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_offset;
    logic        busy, tile_done, error;

    logic [3:0]  eng_done = '0;
    logic        inj_pred = 1'b0;
    int          eng_k = 1;
    logic        eng_early = 1'b0;
    logic        ready_toggle = 1'b0;
    int          rem [4];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // monitor state
    int          clr_req = 0, clr_ack = 0;
    int          n_ent, n_itx, n_pred, n_rec, n_tile, n_err, n_both, n_beat;
    int          bad_seq, hold_bad, hold_seen;
    int          ent_cyc, itx_cyc, pred_cyc, beat_cyc, tile_cyc, err_cyc;
    logic [31:0] last_off, prev_off;
    logic        prev_stall;
    logic [31:0] sb_q[$];

    assign ent_done   = eng_done[0];
    assign itx_done   = eng_done[1];
    assign pred_done  = eng_done[2] | inj_pred;
    assign recon_done = eng_done[3];

    sb_stage_scheduler #(.SB_LOG2(6), .BURST_PIX(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_frame_width(fw), .i_frame_height(fh),
        .o_ent_start(ent_start), .o_itx_start(itx_start),
        .o_pred_start(pred_start), .o_recon_start(recon_start),
        .i_ent_done(ent_done), .i_itx_done(itx_done),
        .i_pred_done(pred_done), .i_recon_done(recon_done),
        .o_sb_row(sb_row), .o_sb_col(sb_col),
        .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_offset(wr_offset),
        .o_busy(busy), .o_tile_done(tile_done), .o_error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engines answer eng_k cycles after their start pulse (optionally also in the pulse cycle)
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            eng_done = '0;
            for (int i = 0; i < 4; i++) rem[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic s;
                s = (i == 0) ? ent_start : (i == 1) ? itx_start :
                    (i == 2) ? pred_start : recon_start;
                eng_done[i] = 1'b0;
                if (s) begin
                    rem[i] = eng_k;
                    eng_done[i] = eng_early;
                end else if (rem[i] > 0) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) eng_done[i] = 1'b1;
                end
            end
        end
        wr_ready = ready_toggle ? ~wr_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            clr_ack = clr_req;
            n_ent = 0; n_itx = 0; n_pred = 0; n_rec = 0; n_tile = 0; n_err = 0; n_both = 0;
            n_beat = 0; bad_seq = 0; hold_bad = 0; hold_seen = 0;
            ent_cyc = -1; itx_cyc = -1; pred_cyc = -1; beat_cyc = -1; tile_cyc = -1;
            err_cyc = -1; last_off = '1; prev_off = '0; prev_stall = 1'b0;
            sb_q.delete();
        end else begin
            if (ent_start) begin
                if (n_ent == 0) ent_cyc = cyc;
                n_ent++;
                sb_q.push_back({sb_row, sb_col});
            end
            if (itx_start) begin
                if (n_itx == 0) itx_cyc = cyc;
                n_itx++;
            end
            if (pred_start) begin
                if (n_pred == 0) pred_cyc = cyc;
                n_pred++;
            end
            if (recon_start) n_rec++;
            if (prev_stall) begin
                hold_seen++;
                if (wr_offset !== prev_off) hold_bad++;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_off = wr_offset;
            if (wr_valid && wr_ready) begin
                if (wr_offset !== 32'(n_beat * 16)) bad_seq++;
                last_off = wr_offset;
                beat_cyc = cyc;
                n_beat++;
            end
            if (tile_done) begin n_tile++; tile_cyc = cyc; end
            if (error) begin n_err++; err_cyc = cyc; end
            if (tile_done && error) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        #1 clr_req++;
        @(negedge clk);
        #1;
    endtask

    // Returns a = cycle index in which the DUT sits in SETUP
    task automatic do_start(input logic [15:0] w, input logic [15:0] h, output int a);
        @(negedge clk);
        start = 1'b1; fw = w; fh = h;
        @(negedge clk);
        start = 1'b0;
        a = cyc;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            #1;
            if (!busy) idle = 1'b1;
        end
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int a;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pulses", {26'd0, ent_start, itx_start, pred_start, recon_start, tile_done,
                             error}, 0);
        check("rst_pos", {sb_row, sb_col}, 0);
        check("rst_wr", wr_offset + {31'd0, wr_valid}, 0);
        rst = 1'b0;

        // 64x64, k=1, ready always high
        clear_mon();
        do_start(16'd64, 16'd64, a);
        wait_idle(2000, "t1_timeout");
        check("t1_ent_cyc", ent_cyc, a + 2);
        check("t1_itx_cyc", itx_cyc, a + 4);
        check("t1_stage_cnt", {n_ent[7:0], n_itx[7:0], n_pred[7:0], n_rec[7:0]}, 32'h01010101);
        check("t1_sb0", (sb_q.size() > 0) ? sb_q[0] : 32'hffff_ffff, 0);
        check("t1_beats", n_beat, 256);
        check("t1_seq", bad_seq, 0);
        check("t1_last_off", last_off, 4080);
        check("t1_tile_cnt", n_tile, 1);
        check("t1_tile_cyc", tile_cyc, a + 267);
        check("t1_tile_after_beat", tile_cyc - beat_cyc, 1);
        check("t1_off_hold", wr_offset, 4096);
        check("t1_err_cnt", n_err, 0);

        // 130x70: 3 columns x 2 rows
        clear_mon();
        do_start(16'd130, 16'd70, a);
        wait_idle(3000, "t2_timeout");
        check("t2_stage_cnt", {n_ent[7:0], n_itx[7:0], n_pred[7:0], n_rec[7:0]}, 32'h06060606);
        check("t2_sb_q_size", sb_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t2_sb_order", (i < sb_q.size()) ? sb_q[i] : 32'hffff_ffff,
                  (32'(i / 3) << 16) | 32'(i % 3));
        end
        check("t2_beats", n_beat, 569);
        check("t2_seq", bad_seq, 0);
        check("t2_last_off", last_off, 9088);
        check("t2_tile_cyc", tile_cyc, a + 630);
        check("t2_pos_hold", {sb_row, sb_col}, 32'h0001_0002);

        // Zero width is rejected
        clear_mon();
        do_start(16'd0, 16'd64, a);
        wait_idle(20, "t3_timeout");
        repeat (3) @(negedge clk);
        #1;
        check("t3_err_cnt", n_err, 1);
        check("t3_err_cyc", err_cyc, a + 1);
        check("t3_no_stage", n_ent + n_itx + n_pred + n_rec, 0);
        check("t3_no_tile", n_tile, 0);
        check("t3_busy", {31'd0, busy}, 0);

        // 64x64 with ready toggling every cycle
        clear_mon();
        ready_toggle = 1'b1;
        do_start(16'd64, 16'd64, a);
        wait_idle(3000, "t4_timeout");
        ready_toggle = 1'b0;
        check("t4_beats", n_beat, 256);
        check("t4_seq", bad_seq, 0);
        check("t4_hold", hold_bad, 0);
        check("t4_stalled", {31'd0, hold_seen > 200}, 1);
        check("t4_last_off", last_off, 4080);
        check("t4_tile_cnt", n_tile, 1);

        // Early done plus a later one at k=3, stray pred_done while in ENT
        clear_mon();
        eng_k = 3;
        eng_early = 1'b1;
        do_start(16'd64, 16'd64, a);
        repeat (3) @(negedge clk);
        #1 inj_pred = 1'b1;
        @(negedge clk);
        #1 inj_pred = 1'b0;
        wait_idle(2000, "t5_timeout");
        eng_early = 1'b0;
        check("t5_ent_cyc", ent_cyc, a + 2);
        check("t5_itx_cyc", itx_cyc, a + 6);
        check("t5_pred_cyc", pred_cyc, a + 10);
        check("t5_stage_cnt", {n_ent[7:0], n_itx[7:0], n_pred[7:0], n_rec[7:0]}, 32'h01010101);
        check("t5_tile_cyc", tile_cyc, a + 275);

        // Reset while in ITX, with a start pulse ignored while busy
        clear_mon();
        do_start(16'd64, 16'd64, a);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (itx_start) seen = 1'b1;
        end
        check("t6_reach_itx", {31'd0, seen}, 1);
        #1 start = 1'b1; fw = 16'd128; fh = 16'd128;
        @(negedge clk);
        #1 start = 1'b0;
        check("t6_busy_start", {15'd0, busy, sb_row}, 32'h0001_0000);
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {25'd0, busy, ent_start, itx_start, pred_start, recon_start,
                              tile_done, error}, 0);
        check("t6_rst_wr", wr_offset + {31'd0, wr_valid}, 0);
        check("t6_rst_pos", {sb_row, sb_col}, 0);
        clear_mon();
        rst = 1'b0;
        eng_k = 1;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_pulse", n_ent + n_itx + n_pred + n_rec + n_tile + n_err, 0);
        check("t6_idle", {31'd0, busy}, 0);
        clear_mon();
        do_start(16'd64, 16'd64, a);
        wait_idle(2000, "t6_timeout");
        check("t6_ent_cyc", ent_cyc, a + 2);
        check("t6_beats", n_beat, 256);
        check("t6_tile_cyc", tile_cyc, a + 267);
        check("t6_both", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
